// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose : state encoding and default widths used by seq_divider and div_step.
// Contents: state_t       - FSM states IDLE, RUN, DONE
//           DEF_DATA_W    - default operand/result width
//           DEF_CNT_W     - default iteration counter width (2^CNT_W > DATA_W)
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 16;

   // Smallest width whose range covers 0..DATA_W.
   localparam int DEF_CNT_W = $clog2(DEF_DATA_W + 1);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one shift-subtract-restore iteration of an unsigned divider
//
// Purpose : purely combinational restoring step, usable by the sequential
//           divider or by an unrolled array of steps.
// Ports   : prem       in  DATA_W  current partial remainder
//           quo        in  DATA_W  quotient shift register (dividend bits shift out of the MSB)
//           divisor    in  DATA_W  denominator
//           prem_next  out DATA_W  partial remainder after this step
//           quo_next   out DATA_W  quotient shift register after this step
module div_step #(
   parameter int DATA_W = div_pkg::DEF_DATA_W
) (
   input  logic [DATA_W-1:0] prem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] prem_next,
   output logic [DATA_W-1:0] quo_next
);

   // Shifted partial remainder: the next dividend bit enters from the quotient MSB.
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] trial;

   assign shifted = {prem, quo[DATA_W-1]};

   // DATA_W+1 bits suffice: shifted < 2*divisor, so trial's MSB is exactly the borrow.
   assign trial = shifted - {1'b0, divisor};

   assign prem_next = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
   assign quo_next  = {quo[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for the accumulator datapath
//
// Purpose : divides dividend (ACC) by divisor (MDR) over DATA_W iterations and
//           returns quotient/remainder with a one-cycle completion pulse.
//           Build option SEQ_DIVIDER_SIGNED_EN selects two's-complement division
//           (truncating toward zero); the default build is unsigned only.
// Ports   : clk          in  1       clock, all state on rising edge
//           rst          in  1       synchronous active-high reset
//           div_load     in  1       start request, accepted in IDLE or DONE
//           dividend     in  DATA_W  numerator, captured on accepted load
//           divisor      in  DATA_W  denominator, captured on accepted load
//           div_out      out DATA_W  registered quotient
//           remainder    out DATA_W  registered remainder
//           complete     out 1       one-cycle pulse when results are valid
//           busy         out 1       high while in RUN
//           div_by_zero  out 1       set with complete when divisor was zero
module seq_divider
   import div_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_load,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] div_out,
   output logic [DATA_W-1:0] remainder,
   output logic              complete,
   output logic              busy,
   output logic              div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] prem;
   logic [DATA_W-1:0] dvsr;
   logic [CNT_W-1:0]  cnt;

   logic [DATA_W-1:0] prem_next;
   logic [DATA_W-1:0] quo_next;

   // Operand values written into the datapath on an accepted load.
   logic [DATA_W-1:0] cap_quo;
   logic [DATA_W-1:0] cap_dvsr;

   // Final results presented to the output registers in DONE.
   logic [DATA_W-1:0] res_quo;
   logic [DATA_W-1:0] res_rem;

   logic              dvsr_zero;

   assign dvsr_zero = (dvsr == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic q_neg;
   logic r_neg;

   always_comb begin
      cap_quo  = dividend;
      cap_dvsr = divisor;
      if (dividend[DATA_W-1]) cap_quo  = '0 - dividend;
      if (divisor[DATA_W-1])  cap_dvsr = '0 - divisor;
   end

   // A zero divisor keeps the raw all-ones quotient regardless of signs;
   // the remainder negation restores the original dividend in that case.
   always_comb begin
      res_quo = quo;
      res_rem = prem;
      if (q_neg && !dvsr_zero) res_quo = '0 - quo;
      if (r_neg)               res_rem = '0 - prem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (div_load && (state == IDLE || state == DONE)) begin
         q_neg <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
         r_neg <= dividend[DATA_W-1];
      end
   end
`else
   always_comb begin
      cap_quo  = dividend;
      cap_dvsr = divisor;
      res_quo  = quo;
      res_rem  = prem;
   end
`endif

   div_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .prem      (prem),
      .quo       (quo),
      .divisor   (dvsr),
      .prem_next (prem_next),
      .quo_next  (quo_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         quo         <= '0;
         prem        <= '0;
         dvsr        <= '0;
         cnt         <= '0;
         div_out     <= '0;
         remainder   <= '0;
         complete    <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         complete <= 1'b0;
         case (state)
            IDLE: begin
               if (div_load) begin
                  quo   <= cap_quo;
                  dvsr  <= cap_dvsr;
                  prem  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               prem <= prem_next;
               quo  <= quo_next;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end

            DONE: begin
               div_out     <= res_quo;
               remainder   <= res_rem;
               div_by_zero <= dvsr_zero;
               complete    <= 1'b1;
               // Back-to-back issue: a load here starts the next operation
               // while this one still reports completion.
               if (div_load) begin
                  quo   <= cap_quo;
                  dvsr  <= cap_dvsr;
                  prem  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the responder for the accumulator datapath's divide request.
- Datapath drives ACC as dividend, MDR as divisor and pulses the load.
- The divider returns quotient on div_out, plus a remainder and a completion pulse.
- The quotient feeds the datapath's ACC input mux. The controller sequences on complete.

Parameters:
- DATA_W, 16, operand/result width; matches ACC/MDR width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- div_load  input  1  start request; sampled on rising edge of clk.
- dividend  input  DATA_W  numerator (ACC_reg); captured when load is accepted.
- divisor  input  DATA_W  denominator (MDR_reg); captured when load is accepted.
- div_out  output  DATA_W  quotient; registered.
- remainder  output  DATA_W  remainder; registered.
- complete  output  1  one-cycle pulse when results are valid.
- busy  output  1  high while an operation is in progress (RUN state).
- div_by_zero  output  1  registered; set with complete when the captured divisor == 0.

Behaviour:
- Reset: synchronous and active-high. Outputs after the reset edge:
  - state=IDLE
  - div_out=0, remainder=0
  - complete=0, busy=0, div_by_zero=0
  - internal shift and counter registers = 0
- Reset mid-operation: aborts the operation. No complete pulse is issued for the aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If div_load=1: capture dividend into the quotient shift register, capture the divisor, clear the partial remainder, set count=0, go to RUN.
  - div_out and remainder keep their last results.
- RUN: one restoring step per cycle.
  - Form {partial remainder, quotient shift register} and shift it left by 1.
  - trial = partial remainder (DATA_W+1 bits) − divisor.
  - If trial is non-negative: partial remainder = trial and quotient LSB = 1. Otherwise: partial remainder is unchanged and quotient LSB = 0.
  - count increments each cycle. After DATA_W steps (count == DATA_W−1 step done), go to DONE.
  - busy=1 throughout RUN.
  - div_load is ignored in RUN; operands are not re-captured.
- DONE:
  - Register div_out=quotient, remainder=partial remainder, and div_by_zero=(captured divisor==0).
  - complete=1 for exactly this cycle.
  - Next state is IDLE. Exception: if div_load=1 in DONE, the new operands are captured and the next state is RUN (back-to-back issue). complete still pulses for the finishing operation.
- Latency:
  - div_load sampled at edge k gives complete=1 in the cycle after edge k+DATA_W+1.
  - With DATA_W=16, complete is visible 17 cycles after the load edge.
- Results remain stable from DONE until the next DONE or reset.
- Divide by zero: no special path; the restoring algorithm yields div_out = all ones and remainder = dividend. div_by_zero=1. Latency is unchanged.
- Width rules:
  - Trial subtraction uses DATA_W+1 bits; its MSB is the borrow.
  - No overflow is possible for unsigned division.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined (two's-complement division):
  - On load, capture the absolute values of both operands. Record q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend).
  - In DONE, negate the quotient if q_neg and negate the remainder if r_neg.
  - The quotient truncates toward zero. Latency is unchanged: the sign fix-up happens in the DONE registration.
  - Divide by zero: div_out = all ones (−1), remainder = dividend, div_by_zero=1.
- Undefined: pure unsigned behaviour as above; no sign logic is synthesised.

Decomposition:
- Shared package (div_pkg):
  - state enum {IDLE, RUN, DONE}
  - DATA_W default constant
  - CNT_W derivation constant
- One combinational sub-module is natural: div_step.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next partial remainder, next quotient (one shift-subtract-restore iteration).
  - div_step can be reused if an unrolled variant is built later.

Test Plan:
- Basic divide: load 100 / 7 → complete exactly 17 cycles after the load edge; div_out=14, remainder=2, div_by_zero=0; complete high for 1 cycle.
- Divide by zero: load 0x04D2 / 0 → div_out=0xFFFF, remainder=0x04D2, div_by_zero=1, same 17-cycle latency.
- Ignored load while busy: 0xFFFF / 1, then pulse div_load with 9 / 3 at cycle 5 of RUN → result 0xFFFF r 0; no re-capture.
- Back-to-back issue: 50 / 5, then div_load held in the DONE cycle with 51 / 5 → first 10 r 0, then 10 r 1, complete pulses 17 cycles apart.
- Reset mid-operation: rst at cycle 8 of RUN → next cycle: IDLE, busy=0, outputs 0; no complete pulse; a subsequent 20 / 6 gives 3 r 2.
- Signed (with SEQ_DIVIDER_SIGNED_EN defined), DATA_W=16:
  - −7 / 2 → div_out=0xFFFD (−3), remainder=0xFFFF (−1).
  - 7 / −2 → div_out=0xFFFD (−3), remainder=1.
